// File: rtl/main_fsm.sv
// Command decoder for echo control: detects NewCmd rising edges, latches the command byte and
// emits a one-cycle echoOn/echoOff pulse when the requested mode differs from the current one.
module main_fsm #(
  parameter logic [7:0] CMD_ECHO_ON  = 8'h45,
  parameter logic [7:0] CMD_ECHO_OFF = 8'h65
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Cmd,
  input  logic       NewCmd,
  output logic       echoOn,
  output logic       echoOff
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DECODE   = 2'd1;
  localparam logic [1:0] ECHO_ON  = 2'd2;
  localparam logic [1:0] ECHO_OFF = 2'd3;

  logic [1:0] state;
  logic [1:0] stateNext;
  logic       echoMode;
  logic [7:0] cmdLatch;
  logic       newCmdPrev;
  logic       cmdEdge;

  assign cmdEdge = NewCmd & ~newCmdPrev;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (cmdEdge) stateNext = DECODE;
      end
      DECODE: begin
        if (cmdLatch == CMD_ECHO_ON && !echoMode) begin
          stateNext = ECHO_ON;
        end else if (cmdLatch == CMD_ECHO_OFF && echoMode) begin
          stateNext = ECHO_OFF;
        end else begin
          stateNext = IDLE;
        end
      end
      ECHO_ON:  stateNext = IDLE;
      ECHO_OFF: stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // Pulses come straight from flops tracking the state, so they are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      echoMode   <= 1'b0;
      cmdLatch   <= 8'h00;
      newCmdPrev <= 1'b0;
      echoOn     <= 1'b0;
      echoOff    <= 1'b0;
    end else begin
      newCmdPrev <= NewCmd;
      state      <= stateNext;
      echoOn     <= (stateNext == ECHO_ON);
      echoOff    <= (stateNext == ECHO_OFF);
      if (state == IDLE && cmdEdge) cmdLatch <= Cmd;
      if (state == ECHO_ON) echoMode <= 1'b1;
      if (state == ECHO_OFF) echoMode <= 1'b0;
    end
  end

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: echo on/off pulses, dropped strobes, held strobes and reset aborts.
module tb_main_fsm;

  logic       clk;
  logic       rst_n;
  logic [7:0] Cmd;
  logic       NewCmd;
  logic       echoOn;
  logic       echoOff;

  int nPass  = 0;
  int nTotal = 0;

  main_fsm dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Cmd    (Cmd),
    .NewCmd (NewCmd),
    .echoOn (echoOn),
    .echoOff(echoOff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset pulse released on a falling edge; returns 1 time unit after the next rising edge.
  task automatic applyReset();
    @(negedge clk);
    rst_n  = 1'b0;
    NewCmd = 1'b0;
    Cmd    = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives a strobe for 'hold' cycles and counts output pulses over 'cycles' cycles.
  // onAt/offAt: index of first pulse sample (0 = just after the edge that sampled the strobe).
  task automatic sendCmd(input logic [7:0] c, input int hold, input int cycles,
                         output int onCnt, output int offCnt, output int onAt, output int offAt);
    onCnt = 0; offCnt = 0; onAt = -1; offAt = -1;
    Cmd    = c;
    NewCmd = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (echoOn) begin
        onCnt++;
        if (onAt < 0) onAt = i;
      end
      if (echoOff) begin
        offCnt++;
        if (offAt < 0) offAt = i;
      end
      if (echoOn && echoOff) offCnt += 100;
      if (i == hold - 1) NewCmd = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; NewCmd = 1'b0; Cmd = 8'h00;
    #2;
    nTotal++;
    if (echoOn !== 1'b0 || echoOff !== 1'b0)
      $display("FAIL reset_outputs: got on=%b off=%b want 0 0", echoOn, echoOff);
    else nPass++;
    nTotal++;
    if (dut.state !== 2'd0 || dut.echoMode !== 1'b0 || dut.cmdLatch !== 8'h00)
      $display("FAIL reset_state: got state=%0d mode=%b latch=%h want 0 0 00",
               dut.state, dut.echoMode, dut.cmdLatch);
    else nPass++;
    applyReset();
  endtask

  task automatic test_echo_on();
    int on, off, onAt, offAt;
    applyReset();
    sendCmd(8'h45, 1, 5, on, off, onAt, offAt);
    nTotal++;
    if (on !== 1 || onAt !== 1)
      $display("FAIL echo_on_pulse: got count=%0d at=%0d want 1 at 1", on, onAt);
    else nPass++;
    nTotal++;
    if (off !== 0) $display("FAIL echo_on_no_off: got %0d want 0", off);
    else nPass++;
    nTotal++;
    if (dut.echoMode !== 1'b1) $display("FAIL echo_on_mode: got %b want 1", dut.echoMode);
    else nPass++;
  endtask

  task automatic test_repeat();
    int on, off, onAt, offAt;
    sendCmd(8'h45, 1, 5, on, off, onAt, offAt);
    nTotal++;
    if (on !== 0 || off !== 0)
      $display("FAIL repeat_on: got on=%0d off=%0d want 0 0", on, off);
    else nPass++;
    sendCmd(8'h65, 1, 5, on, off, onAt, offAt);
    nTotal++;
    if (off !== 1 || offAt !== 1 || on !== 0)
      $display("FAIL echo_off_pulse: got off=%0d at=%0d on=%0d want 1 at 1, 0", off, offAt, on);
    else nPass++;
    sendCmd(8'h65, 1, 5, on, off, onAt, offAt);
    nTotal++;
    if (on !== 0 || off !== 0)
      $display("FAIL repeat_off: got on=%0d off=%0d want 0 0", on, off);
    else nPass++;
  endtask

  task automatic test_ignored();
    int on, off, onAt, offAt;
    applyReset();
    sendCmd(8'h65, 1, 5, on, off, onAt, offAt);
    nTotal++;
    if (on !== 0 || off !== 0)
      $display("FAIL off_when_off: got on=%0d off=%0d want 0 0", on, off);
    else nPass++;
    Cmd = 8'h41; NewCmd = 1'b1;
    @(posedge clk); #1;
    NewCmd = 1'b0;
    nTotal++;
    if (dut.state !== 2'd1 || dut.cmdLatch !== 8'h41)
      $display("FAIL unknown_decode: got state=%0d latch=%h want 1 41", dut.state, dut.cmdLatch);
    else nPass++;
    @(posedge clk); #1;
    nTotal++;
    if (dut.state !== 2'd0 || echoOn !== 1'b0 || echoOff !== 1'b0)
      $display("FAIL unknown_idle: got state=%0d on=%b off=%b want 0 0 0",
               dut.state, echoOn, echoOff);
    else nPass++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_hold();
    int on, off, onAt, offAt;
    applyReset();
    sendCmd(8'h45, 5, 8, on, off, onAt, offAt);
    nTotal++;
    if (on !== 1 || off !== 0)
      $display("FAIL held_strobe: got on=%0d off=%0d want 1 0", on, off);
    else nPass++;
  endtask

  task automatic test_back_to_back();
    int on = 0;
    int off = 0;
    applyReset();
    Cmd = 8'h45; NewCmd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (echoOn) on++;
      if (echoOff) off++;
      if (i == 0) NewCmd = 1'b0;
      if (i == 1) begin
        Cmd = 8'h65; NewCmd = 1'b1;
      end
      if (i == 2) NewCmd = 1'b0;
    end
    nTotal++;
    if (on !== 1 || off !== 0 || dut.echoMode !== 1'b1)
      $display("FAIL back_to_back: got on=%0d off=%0d mode=%b want 1 0 1", on, off, dut.echoMode);
    else nPass++;
  endtask

  task automatic test_newcmd_at_reset();
    int on = 0;
    int onAt = -1;
    @(negedge clk);
    rst_n = 1'b0; Cmd = 8'h45; NewCmd = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (echoOn) begin
        on++;
        if (onAt < 0) onAt = i;
      end
      if (i == 0) NewCmd = 1'b0;
    end
    nTotal++;
    if (on !== 1 || onAt !== 1)
      $display("FAIL newcmd_high_at_reset: got count=%0d at=%0d want 1 at 1", on, onAt);
    else nPass++;
  endtask

  task automatic test_reset_mid();
    int on, off, onAt, offAt;
    applyReset();
    Cmd = 8'h45; NewCmd = 1'b1;
    @(posedge clk); #1;
    NewCmd = 1'b0;
    @(posedge clk); #1;
    nTotal++;
    if (echoOn !== 1'b1) $display("FAIL mid_pulse_high: got %b want 1", echoOn);
    else nPass++;
    #2;
    rst_n = 1'b0;
    #1;
    nTotal++;
    if (echoOn !== 1'b0 || dut.echoMode !== 1'b0 || dut.state !== 2'd0)
      $display("FAIL mid_reset_abort: got on=%b mode=%b state=%0d want 0 0 0",
               echoOn, dut.echoMode, dut.state);
    else nPass++;
    applyReset();
    sendCmd(8'h65, 1, 5, on, off, onAt, offAt);
    nTotal++;
    if (on !== 0 || off !== 0)
      $display("FAIL after_mid_reset_off: got on=%0d off=%0d want 0 0", on, off);
    else nPass++;
    sendCmd(8'h45, 1, 5, on, off, onAt, offAt);
    nTotal++;
    if (on !== 1 || off !== 0)
      $display("FAIL after_mid_reset_on: got on=%0d off=%0d want 1 0", on, off);
    else nPass++;
  endtask

  initial begin
    test_reset();
    test_echo_on();
    test_repeat();
    test_ignored();
    test_hold();
    test_back_to_back();
    test_newcmd_at_reset();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
